// File: rtl/timer_tick_rx.sv
// ---------------------------------------------------------------------------
// timer_tick_rx
//
// Receiving end of the 100 us timer toggle. The incoming square wave is
// synchronised into the clk_i domain, and every edge (either polarity) is
// turned into a one-cycle tick. The ticks feed a running tick counter and a
// divider that produces a millisecond pulse. A timeout counter watches for
// the toggle going quiet and declares the source lost.
//
// State flow: IDLE -> ACQUIRE -> LOCKED. ACQUIRE swallows the first edge to
// align to the source. A timeout in ACQUIRE or LOCKED moves to LOST. In LOST,
// the next edge re-enters ACQUIRE.
//
// Optional feature macro: TIMER_TICK_EARLY_CHECK_EN
//   When defined, this adds err_early_o. It is a sticky flag that is set when a
//   LOCKED edge arrives fewer than MIN_CYC cycles after the previous edge.
//   lost_clr_i clears it.
//
// Ports:
//   clk_i        system clock
//   rst_i        synchronous, active-high reset
//   timer_in_i   100 us toggle input, may be asynchronous to clk_i
//   enable_i     1 = run, 0 = return to IDLE with outputs quiet
//   lost_clr_i   one-cycle pulse clearing the sticky flags
//   tick_o       one-cycle pulse per accepted edge
//   ms_pulse_o   one-cycle pulse every DIV_N ticks (coincident with tick_o)
//   tick_cnt_o   ticks since lock, wraps modulo 2^CNT_W
//   locked_o     high while in LOCKED
//   lost_o       sticky loss flag
//   err_early_o  sticky early-edge flag (only with TIMER_TICK_EARLY_CHECK_EN)
// ---------------------------------------------------------------------------
module timer_tick_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 6000,
  parameter int DIV_N       = 10,
  parameter int CNT_W       = 16,
  parameter int MIN_CYC     = 4000
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             timer_in_i,
  input  logic             enable_i,
  input  logic             lost_clr_i,
  output logic             tick_o,
  output logic             ms_pulse_o,
  output logic [CNT_W-1:0] tick_cnt_o,
  output logic             locked_o,
  output logic             lost_o
`ifdef TIMER_TICK_EARLY_CHECK_EN
  ,
  output logic             err_early_o
`endif
);

  localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);
  localparam int DIV_W = (DIV_N > 1) ? $clog2(DIV_N) : 1;

  localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT_CYC);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_N - 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ACQUIRE = 2'd1;
  localparam logic [1:0] ST_LOCKED  = 2'd2;
  localparam logic [1:0] ST_LOST    = 2'd3;

  // Reject illegal configurations at elaboration time.
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || MIN_CYC < 0) begin : g_param_check
    $error("timer_tick_rx: illegal SYNC_STAGES or MIN_CYC");
  end

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic [1:0]             state_q, state_d;
  logic [TO_W-1:0]        to_cnt_q, to_cnt_d;
  logic [DIV_W-1:0]       div_q, div_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   tick_q, tick_d;
  logic                   ms_q, ms_d;
  logic                   lost_q, lost_d;
  logic                   sync_out;
  logic                   edge_det;
  logic                   timeout_hit;
  logic                   lost_set;
`ifdef TIMER_TICK_EARLY_CHECK_EN
  logic                   err_q, err_d;
  logic                   err_set;
`endif

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign edge_det = sync_out ^ prev_q;

  // The timeout fires on the cycle that would move the counter to
  // TIMEOUT_CYC. As a result, LOST is registered exactly TIMEOUT_CYC cycles
  // after the tick of the last edge.
  assign timeout_hit = !edge_det && (to_cnt_q >= TO_LAST);

  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], timer_in_i};
    prev_d   = sync_out;
    state_d  = state_q;
    div_d    = div_q;
    cnt_d    = cnt_q;
    tick_d   = 1'b0;
    ms_d     = 1'b0;
    lost_set = 1'b0;
`ifdef TIMER_TICK_EARLY_CHECK_EN
    err_set  = 1'b0;
`endif

    if (edge_det) begin
      to_cnt_d = '0;
    end else if (to_cnt_q != TO_MAX) begin
      to_cnt_d = to_cnt_q + 1'b1;
    end else begin
      to_cnt_d = to_cnt_q;
    end

    case (state_q)
      ST_IDLE: begin
        to_cnt_d = '0;
        div_d    = '0;
        cnt_d    = '0;
        if (enable_i) state_d = ST_ACQUIRE;
      end
      ST_ACQUIRE: begin
        if (edge_det) begin
          state_d = ST_LOCKED;
        end else if (timeout_hit) begin
          state_d  = ST_LOST;
          lost_set = 1'b1;
        end
      end
      ST_LOCKED: begin
        if (edge_det) begin
          tick_d = 1'b1;
          cnt_d  = cnt_q + 1'b1;
          if (div_q == DIV_LAST) begin
            ms_d  = 1'b1;
            div_d = '0;
          end else begin
            div_d = div_q + 1'b1;
          end
`ifdef TIMER_TICK_EARLY_CHECK_EN
          err_set = (32'(to_cnt_q) < MIN_CYC);
`endif
        end else if (timeout_hit) begin
          state_d  = ST_LOST;
          lost_set = 1'b1;
        end
      end
      default: begin
        if (edge_det) begin
          state_d = ST_ACQUIRE;
          div_d   = '0;
          cnt_d   = '0;
        end
      end
    endcase

    // A disable overrides everything. The sticky flags keep their value,
    // apart from an explicit clear.
    if (!enable_i) begin
      state_d  = ST_IDLE;
      to_cnt_d = '0;
      div_d    = '0;
      cnt_d    = '0;
      tick_d   = 1'b0;
      ms_d     = 1'b0;
      lost_set = 1'b0;
`ifdef TIMER_TICK_EARLY_CHECK_EN
      err_set  = 1'b0;
`endif
    end

    // A set takes priority over a clear in the same cycle.
    if (lost_set)        lost_d = 1'b1;
    else if (lost_clr_i) lost_d = 1'b0;
    else                 lost_d = lost_q;
`ifdef TIMER_TICK_EARLY_CHECK_EN
    if (err_set)         err_d = 1'b1;
    else if (lost_clr_i) err_d = 1'b0;
    else                 err_d = err_q;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q   <= '0;
      prev_q   <= 1'b0;
      state_q  <= ST_IDLE;
      to_cnt_q <= '0;
      div_q    <= '0;
      cnt_q    <= '0;
      tick_q   <= 1'b0;
      ms_q     <= 1'b0;
      lost_q   <= 1'b0;
`ifdef TIMER_TICK_EARLY_CHECK_EN
      err_q    <= 1'b0;
`endif
    end else begin
      sync_q   <= sync_d;
      prev_q   <= prev_d;
      state_q  <= state_d;
      to_cnt_q <= to_cnt_d;
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      tick_q   <= tick_d;
      ms_q     <= ms_d;
      lost_q   <= lost_d;
`ifdef TIMER_TICK_EARLY_CHECK_EN
      err_q    <= err_d;
`endif
    end
  end

  assign tick_o     = tick_q;
  assign ms_pulse_o = ms_q;
  assign tick_cnt_o = cnt_q;
  assign locked_o   = (state_q == ST_LOCKED);
  assign lost_o     = lost_q;
`ifdef TIMER_TICK_EARLY_CHECK_EN
  assign err_early_o = err_q;
`endif

endmodule

// File: tb/tb_timer_tick_rx.sv
// Testbench for timer_tick_rx. It runs with scaled-down timing so the whole
// run stays short: toggles every 50 cycles, a timeout of 60 cycles, a
// minimum spacing of 40 cycles, and an 8-bit tick counter so that wrap is
// reachable. The driver pushes the expected tick (cycle, ms pulse, count,
// early flag) into a queue. A separate monitor pops an entry and compares it
// whenever tick_o is seen.
module tb_timer_tick_rx;

   localparam int CNT_W   = 8;
   localparam int TIMEOUT = 60;
   localparam int MIN_GAP = 40;
   localparam int GAP     = 50;
   localparam int DIV     = 10;

   logic clk = 1'b0;
   logic rst;
   logic timerIn;
   logic enable;
   logic lostClr;
   logic tickO;
   logic msPulseO;
   logic [CNT_W-1:0] tickCntO;
   logic lockedO;
   logic lostO;
`ifdef TIMER_TICK_EARLY_CHECK_EN
   logic errEarlyO;
`endif

   typedef struct {
      int             cyc;
      logic           ms;
      logic [CNT_W-1:0] cnt;
      logic           err;
   } expT;

   expT expQ[$];
   expT monEntry;
   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   logic [CNT_W-1:0] expCnt;
   int expDiv;
   logic expErr;
   int prevGap;

   timer_tick_rx #(
      .SYNC_STAGES(2),
      .TIMEOUT_CYC(TIMEOUT),
      .DIV_N(DIV),
      .CNT_W(CNT_W),
      .MIN_CYC(MIN_GAP)
   ) dut (
      .clk_i(clk),
      .rst_i(rst),
      .timer_in_i(timerIn),
      .enable_i(enable),
      .lost_clr_i(lostClr),
      .tick_o(tickO),
      .ms_pulse_o(msPulseO),
      .tick_cnt_o(tickCntO),
      .locked_o(lockedO),
      .lost_o(lostO)
`ifdef TIMER_TICK_EARLY_CHECK_EN
      ,
      .err_early_o(errEarlyO)
`endif
   );

   // Free-running clock, with a cycle index used to timestamp expected ticks.
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // This is the single comparison point. It counts every check and reports
   // each miscompare.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Toggle the input. If the DUT should answer with a tick, queue the
   // expected tick, which arrives 3 cycles later (two sync flops plus the
   // output register). Then idle for gap cycles.
   task automatic applyStimulus(input int gap, input bit expectTick);
      expT e;
      timerIn = ~timerIn;
      if (expectTick) begin
         e.cyc  = cyc + 3;
         e.ms   = (expDiv == DIV - 1);
         expDiv = (expDiv == DIV - 1) ? 0 : expDiv + 1;
         expCnt = expCnt + 1'b1;
         if (prevGap < MIN_GAP) expErr = 1'b1;
         e.cnt  = expCnt;
         e.err  = expErr;
         expQ.push_back(e);
      end
      prevGap = gap;
      waitCycles(gap);
   endtask

   // The monitor matches every tick the DUT produces against the next queued
   // expectation. A tick that arrives when nothing is queued is an error.
   always @(negedge clk) begin
      if (!rst && tickO === 1'b1) begin
         if (expQ.size() == 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL unexpectedTick: got tick at cycle %0d, expected none (count %0d)", cyc, tickCntO);
         end else begin
            monEntry = expQ.pop_front();
            checkOutput("tickCycle", cyc, monEntry.cyc);
            checkOutput("tickCnt", 32'(tickCntO), 32'(monEntry.cnt));
            checkOutput("msPulse", 32'(msPulseO), 32'(monEntry.ms));
`ifdef TIMER_TICK_EARLY_CHECK_EN
            checkOutput("errEarlyOnTick", 32'(errEarlyO), 32'(monEntry.err));
`endif
         end
      end
   end

   // Directed sequence: reset, lock and tick, loss, re-acquire, set-vs-clear,
   // wrap, disable mid-stream, early edge, then reset mid-operation.
   initial begin
      rst = 1'b1;
      timerIn = 1'b0;
      enable = 1'b0;
      lostClr = 1'b0;
      expCnt = '0;
      expDiv = 0;
      expErr = 1'b0;
      prevGap = 1000;
      waitCycles(3);
      checkOutput("rstTick", 32'(tickO), 0);
      checkOutput("rstMs", 32'(msPulseO), 0);
      checkOutput("rstCnt", 32'(tickCntO), 0);
      checkOutput("rstLocked", 32'(lockedO), 0);
      checkOutput("rstLost", 32'(lostO), 0);
      rst = 1'b0;
      waitCycles(2);

      // Lock and run 25 toggles. The first toggle is swallowed, so 24 ticks
      // follow, with ms pulses on ticks 10 and 20.
      enable = 1'b1;
      waitCycles(10);
      applyStimulus(GAP, 1'b0);
      for (int i = 0; i < 24; i++) applyStimulus(GAP, 1'b1);
      checkOutput("lockCnt", 32'(tickCntO), 24);
      checkOutput("lockLocked", 32'(lockedO), 1);
      checkOutput("lockLost", 32'(lostO), 0);
      checkOutput("lockQueueDrained", expQ.size(), 0);

      // Go quiet. Loss must register exactly TIMEOUT cycles after the last tick.
      waitCycles(TIMEOUT + 3 - GAP - 1);
      checkOutput("preLossLost", 32'(lostO), 0);
      checkOutput("preLossLocked", 32'(lockedO), 1);
      waitCycles(1);
      checkOutput("lossLost", 32'(lostO), 1);
      checkOutput("lossLocked", 32'(lockedO), 0);
      checkOutput("lossCntHeld", 32'(tickCntO), 24);

      // Resume. LOST goes to ACQUIRE and clears the count; one more edge
      // locks, then ticks restart from 1.
      expCnt = '0;
      expDiv = 0;
      applyStimulus(10, 1'b0);
      checkOutput("reacqCnt", 32'(tickCntO), 0);
      checkOutput("reacqLocked", 32'(lockedO), 0);
      checkOutput("reacqLostSticky", 32'(lostO), 1);
      applyStimulus(GAP, 1'b0);
      for (int i = 0; i < 3; i++) applyStimulus(GAP, 1'b1);
      checkOutput("relockCnt", 32'(tickCntO), 3);
      checkOutput("relockLostSticky", 32'(lostO), 1);
      lostClr = 1'b1;
      waitCycles(1);
      lostClr = 1'b0;
      checkOutput("lostCleared", 32'(lostO), 0);

      // Loss and clear in the same cycle. The set must win.
      waitCycles(TIMEOUT + 3 - GAP - 2);
      lostClr = 1'b1;
      waitCycles(1);
      lostClr = 1'b0;
      checkOutput("setBeatsClear", 32'(lostO), 1);
      checkOutput("setBeatsClearLocked", 32'(lockedO), 0);
      lostClr = 1'b1;
      waitCycles(1);
      lostClr = 1'b0;
      checkOutput("lostCleared2", 32'(lostO), 0);

      // Re-acquire, then run 257 ticks so the 8-bit count wraps 255 -> 0 -> 1.
      // The ms cadence carries on every 10 ticks.
      expCnt = '0;
      expDiv = 0;
      applyStimulus(10, 1'b0);
      applyStimulus(GAP, 1'b0);
      for (int i = 0; i < 257; i++) applyStimulus(GAP, 1'b1);
      checkOutput("wrapCnt", 32'(tickCntO), 1);
      checkOutput("wrapQueueDrained", expQ.size(), 0);

      // Drop enable on the very cycle an edge is being registered. No tick
      // should appear, and the counters and lock should clear next cycle.
      applyStimulus(2, 1'b0);
      enable = 1'b0;
      waitCycles(1);
      checkOutput("disTick", 32'(tickO), 0);
      checkOutput("disMs", 32'(msPulseO), 0);
      checkOutput("disCnt", 32'(tickCntO), 0);
      checkOutput("disLocked", 32'(lockedO), 0);
      expCnt = '0;
      expDiv = 0;
      applyStimulus(10, 1'b0);
      checkOutput("disIdleLocked", 32'(lockedO), 0);
      enable = 1'b1;
      waitCycles(5);
      applyStimulus(GAP, 1'b0);
      applyStimulus(GAP, 1'b1);
      checkOutput("reenCnt", 32'(tickCntO), 1);

      // Spacing 50, then 30. The 30-spaced edge is early but is still counted.
      applyStimulus(GAP, 1'b1);
      applyStimulus(30, 1'b1);
      applyStimulus(GAP, 1'b1);
      checkOutput("earlyCnt", 32'(tickCntO), 4);
`ifdef TIMER_TICK_EARLY_CHECK_EN
      checkOutput("earlySticky", 32'(errEarlyO), 1);
`endif
      lostClr = 1'b1;
      waitCycles(1);
      lostClr = 1'b0;
`ifdef TIMER_TICK_EARLY_CHECK_EN
      checkOutput("earlyCleared", 32'(errEarlyO), 0);
`endif
      checkOutput("earlyLost", 32'(lostO), 0);

      // Reset mid-operation returns everything to the reset values.
      rst = 1'b1;
      waitCycles(1);
      checkOutput("midRstCnt", 32'(tickCntO), 0);
      checkOutput("midRstLocked", 32'(lockedO), 0);
      checkOutput("midRstLost", 32'(lostO), 0);
      rst = 1'b0;
      waitCycles(5);
      checkOutput("finalQueueDrained", expQ.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
